// File: rtl/muldiv_pkg.sv
// muldiv_seq shared definitions: FSM states, decoder op controls
// and the operand-width / radix legality check.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // {op_div, sign_a, sign_b} as produced by the decoder
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b011;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b000;
  localparam logic [2:0] OP_DIV    = 3'b110;
  localparam logic [2:0] OP_DIVU   = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b100;

  function automatic bit step_ok(int rv, int step);
    return (rv == 16 || rv == 32) &&
           (step == 1 || step == 2 || step == 4) &&
           (rv % step == 0);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-side handshake and result bundle of the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int RV = 16
);
  logic          start;
  logic          kill;
  logic          op_div;
  logic          sign_a;
  logic          sign_b;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic          busy;
  logic          done;
  logic          div0;
  logic [RV-1:0] result_lo;
  logic [RV-1:0] result_hi;

  modport master (
    output start, kill, op_div, sign_a, sign_b, a, b,
    input  busy, done, div0, result_lo, result_hi
  );

  modport slave (
    input  start, kill, op_div, sign_a, sign_b, a, b,
    output busy, done, div0, result_lo, result_hi
  );
endinterface

// File: rtl/muldiv_step.sv
// One STEP-bit iteration: shift-add multiply or restoring
// shift-subtract divide on unsigned magnitudes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int RV   = 16,
  parameter int STEP = 1
) (
  input  logic          div_i,
  input  logic [2*RV-1:0] acc_i,
  input  logic [RV-1:0] m_i,
  output logic [2*RV-1:0] acc_o
);

  logic [RV+STEP-1:0] sum;
  logic [RV:0]        rem;
  logic [RV-1:0]      quo;

  always_comb begin
    // multiply: {hi, multiplier} with multiplier bits consumed LSB first
    sum = {{STEP{1'b0}}, acc_i[2*RV-1:RV]};
    for (int k = 0; k < STEP; k++) begin
      if (acc_i[k]) sum = sum + ({{STEP{1'b0}}, m_i} << k);
    end
    // divide: {partial remainder, dividend/quotient}
    rem = {1'b0, acc_i[2*RV-1:RV]};
    quo = acc_i[RV-1:0];
    for (int k = 0; k < STEP; k++) begin
      rem = {rem[RV-1:0], quo[RV-1]};
      quo = {quo[RV-2:0], 1'b0};
      if (rem >= {1'b0, m_i}) begin
        rem    = rem - {1'b0, m_i};
        quo[0] = 1'b1;
      end
    end
    if (div_i) acc_o = {rem[RV-1:0], quo};
    else       acc_o = {sum, acc_i[RV-1:STEP]};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed/unsigned multiply/divide unit beside the ALU:
// FSM, iteration counter, sign fixup and result registers.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int RV   = 16,
  parameter int STEP = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  localparam int N  = RV / STEP;
  localparam int CW = $clog2(N + 1);

  if (!step_ok(RV, STEP)) begin : g_bad_cfg
    $error("muldiv_seq: illegal RV/STEP combination");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*RV-1:0] acc_q, acc_d, acc_step, prod;
  logic [RV-1:0]   m_q, m_d;
  logic            div_q, div_d;
  logic            dz_q, dz_d;
  logic            negl_q, negl_d;
  logic            negh_q, negh_d;
  logic [RV-1:0]   lo_q, lo_d;
  logic [RV-1:0]   hi_q, hi_d;
  logic            div0_q, div0_d;
  logic            done_q, done_d;
  logic            sa, sb;
  logic [RV-1:0]   ma, mb;

  muldiv_step #(.RV(RV), .STEP(STEP)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    div_d   = div_q;
    dz_d    = dz_q;
    negl_d  = negl_q;
    negh_d  = negh_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    // divide signedness follows sign_a for both operands
    sa   = bus.sign_a & bus.a[RV-1];
    sb   = (bus.op_div ? bus.sign_a : bus.sign_b) & bus.b[RV-1];
    ma   = sa ? -bus.a : bus.a;
    mb   = sb ? -bus.b : bus.b;
    prod = negl_q ? -acc_q : acc_q;
    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            div_d  = bus.op_div;
            dz_d   = bus.op_div && (bus.b == '0);
            negl_d = sa ^ sb;
            negh_d = sa;
            cnt_d  = CW'(N);
            if (bus.op_div) begin
              m_d   = mb;
              acc_d = {{RV{1'b0}}, dz_d ? bus.a : ma};
            end else begin
              m_d   = ma;
              acc_d = {{RV{1'b0}}, mb};
            end
            state_d = dz_d ? S_FIX : S_RUN;
          end
        end
        S_RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (dz_q) begin
            lo_d   = '1;
            hi_d   = acc_q[RV-1:0];
            div0_d = 1'b1;
          end else if (div_q) begin
            lo_d   = negl_q ? -acc_q[RV-1:0] : acc_q[RV-1:0];
            hi_d   = negh_q ? -acc_q[2*RV-1:RV] : acc_q[2*RV-1:RV];
            div0_d = 1'b0;
          end else begin
            lo_d   = prod[RV-1:0];
            hi_d   = prod[2*RV-1:RV];
            div0_d = 1'b0;
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      negl_q  <= 1'b0;
      negh_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      negl_q  <= negl_d;
      negh_q  <= negh_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.div0      = div0_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench: two muldiv_seq instances (STEP=1, STEP=4)
// against an integer-arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  muldiv_if #(.RV(16)) b0 ();
  muldiv_if #(.RV(16)) b1 ();

  muldiv_seq #(.RV(16), .STEP(1)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave)
  );
  muldiv_seq #(.RV(16), .STEP(4)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        div0;
    logic [15:0] lo;
    logic [15:0] hi;
  } obs_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [35:0] got, logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic obs_t peek(int u);
    obs_t o;
    if (u == 0) begin
      o.busy = b0.busy; o.done = b0.done; o.div0 = b0.div0;
      o.lo = b0.result_lo; o.hi = b0.result_hi;
    end else begin
      o.busy = b1.busy; o.done = b1.done; o.div0 = b1.div0;
      o.lo = b1.result_lo; o.hi = b1.result_hi;
    end
    return o;
  endfunction

  task automatic drive(int u, logic st, logic kl, logic [2:0] op,
                       logic [15:0] a, logic [15:0] b);
    if (u == 0) begin
      b0.start = st; b0.kill = kl;
      {b0.op_div, b0.sign_a, b0.sign_b} = op;
      b0.a = a; b0.b = b;
    end else begin
      b1.start = st; b1.kill = kl;
      {b1.op_div, b1.sign_a, b1.sign_b} = op;
      b1.a = a; b1.b = b;
    end
  endtask

  function automatic void model(logic [2:0] op, logic [15:0] a,
                                logic [15:0] b, output logic [15:0] lo,
                                output logic [15:0] hi, output logic d0);
    longint av, bv, p, q, r;
    av = op[1] ? longint'($signed(a)) : longint'(a);
    d0 = 1'b0;
    if (!op[2]) begin
      bv = op[0] ? longint'($signed(b)) : longint'(b);
      p  = av * bv;
      lo = p[15:0];
      hi = p[31:16];
    end else if (b == 16'h0) begin
      lo = 16'hFFFF;
      hi = a;
      d0 = 1'b1;
    end else begin
      bv = op[1] ? longint'($signed(b)) : longint'(b);
      q  = av / bv;
      r  = av % bv;
      lo = q[15:0];
      hi = r[15:0];
    end
  endfunction

  // caller is at a negedge; returns at the negedge where done is seen
  task automatic run_op(int u, logic [2:0] op, logic [15:0] a,
                        logic [15:0] b, string tag);
    logic [15:0] elo, ehi;
    logic        ed0;
    int          n, cyc;
    obs_t        o;
    model(op, a, b, elo, ehi, ed0);
    n = (op[2] && b == 16'h0) ? 1 : ((u == 0) ? 16 : 4) + 1;
    drive(u, 1'b1, 1'b0, op, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(u, 1'b0, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
    o = peek(u);
    chk({tag, "/busy1"}, 36'(o.busy), 36'(1));
    chk({tag, "/done0"}, 36'(o.done), 36'(0));
    cyc = 0;
    while (!o.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      o = peek(u);
    end
    chk({tag, "/lat"}, 36'(cyc), 36'(n));
    chk({tag, "/busy0"}, 36'(o.busy), 36'(0));
    chk({tag, "/res"}, {3'b0, o.div0, o.hi, o.lo}, {3'b0, ed0, ehi, elo});
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h8000;
      3: v = 16'h0001;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [2:0] ops [8];
    logic [2:0] op;
    obs_t o;
    int   nd;
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 3'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      o = peek(u);
      chk($sformatf("rst%0d", u), 36'(o), 36'(0));
    end

    run_op(0, OP_MULHU, 16'h1234, 16'h0056, "mulu");
    run_op(0, OP_MULH, 16'hFFFD, 16'h0005, "muls");
    run_op(0, OP_MULHSU, 16'hFFFD, 16'h8000, "mulsu");
    run_op(0, OP_DIV, 16'hFFF9, 16'h0002, "divs");
    run_op(0, OP_DIV, 16'h8000, 16'hFFFF, "ovf");
    run_op(0, OP_DIVU, 16'h0064, 16'h0000, "dz");
    run_op(0, OP_REMU, 16'h0007, 16'h0003, "remu");
    run_op(1, OP_DIVU, 16'hFFFF, 16'h0010, "s4div");
    run_op(1, OP_MULH, 16'h8000, 16'h8000, "s4b2b");
    run_op(1, OP_DIV, 16'h8000, 16'h0000, "s4dz");
    run_op(1, OP_REM, 16'hFFF9, 16'h0002, "s4rem");

    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op[2]) op[0] = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(i % 2, op, pick(), pick(), $sformatf("rnd%0d", i));
    end

    // kill mid-RUN: no done, previous results held
    run_op(0, OP_MULHU, 16'h1234, 16'h0056, "prekill");
    @(negedge clk);
    o = peek(0);
    chk("pulse1", 36'(o.done), 36'(0));
    drive(0, 1'b1, 1'b0, OP_MULH, 16'h7777, 16'h3333);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b0, 16'h0, 16'h0);
    repeat (5) @(negedge clk);
    drive(0, 1'b0, 1'b1, 3'b0, 16'h0, 16'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b0, 16'h0, 16'h0);
    o = peek(0);
    chk("kill/busy", 36'(o.busy), 36'(0));
    chk("kill/hold", {3'b0, o.div0, o.hi, o.lo}, {4'b0, 16'h0006, 16'h1D78});
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (peek(0).done) nd++;
    end
    chk("kill/nodone", 36'(nd), 36'(0));

    // start and kill together: dropped
    drive(0, 1'b1, 1'b1, OP_MULHU, 16'h0002, 16'h0003);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b0, 16'h0, 16'h0);
    o = peek(0);
    chk("sk/busy", 36'(o.busy), 36'(0));
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (peek(0).done) nd++;
    end
    chk("sk/nodone", 36'(nd), 36'(0));
    o = peek(0);
    chk("sk/hold", {3'b0, o.div0, o.hi, o.lo}, {4'b0, 16'h0006, 16'h1D78});

    // reset mid-RUN clears outputs on both units
    run_op(1, OP_DIVU, 16'h0000, 16'h0000, "predz");
    drive(0, 1'b1, 1'b0, OP_MULH, 16'h1111, 16'h2222);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      o = peek(u);
      chk($sformatf("midrst%0d", u), 36'(o), 36'(0));
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_op(0, OP_MULHU, 16'h1234, 16'h0056, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
